// File: rtl/irq_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : irq_pkg
//  Description : Shared constants, index-width helper and ack-index type used
//                by the pending-capture stage and the downstream encoder.
//  Revision    : 1.0  initial release
// ============================================================================
package irq_pkg;

    // Default number of request lines; matches the encoder's default width.
    localparam int c_DEFAULT_WIDTH = 4;

    // Index width for a given line count; never returns 0 so a 1-line build
    // still has a legal index port.
    function automatic int idx_w(input int width);
        return (width > 1) ? $clog2(width) : 1;
    endfunction

    // Ack/encoder index type at the default width.
    typedef logic [idx_w(c_DEFAULT_WIDTH)-1:0] ack_idx_t;

endpackage
`default_nettype wire

// File: rtl/irq_pending_capture_if.sv
`default_nettype none
// ============================================================================
//  Module      : irq_pending_capture_if
//  Description : Request/ack/pending bundle between the request source and
//                consumer (master) and the pending-capture stage (slave).
//  Revision    : 1.0  initial release
// ============================================================================
interface irq_pending_capture_if
    import irq_pkg::*;
#(
    parameter int WIDTH = c_DEFAULT_WIDTH
);
    localparam int IDXW = idx_w(WIDTH);

    logic [WIDTH-1:0] req_in;
    logic [WIDTH-1:0] en;
    logic             ack;
    logic [IDXW-1:0]  ack_idx;
    logic             ovf_clr;
    logic [WIDTH-1:0] pending;
    logic             any_pending;
    logic [WIDTH-1:0] overflow;

    modport master (
        output req_in, en, ack, ack_idx, ovf_clr,
        input  pending, any_pending, overflow
    );

    modport slave (
        input  req_in, en, ack, ack_idx, ovf_clr,
        output pending, any_pending, overflow
    );

endinterface
`default_nettype wire

// File: rtl/irq_sync2.sv
`default_nettype none
// ============================================================================
//  Module      : irq_sync2
//  Description : Single-bit two-flop synchronizer for an asynchronous request
//                line; both stages reset to 0.
//  Revision    : 1.0  initial release
// ============================================================================
module irq_sync2 (
    input  wire logic clk,
    input  wire logic rst,
    input  wire logic d,
    output logic      q
);
    logic r_meta;
    logic r_sync;

    // Two back-to-back stages; the first may go metastable, the second is used.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= d;
            r_sync <= r_meta;
        end
    end

    assign q = r_sync;

endmodule
`default_nettype wire

// File: rtl/irq_pending_capture.sv
`default_nettype none
// ============================================================================
//  Module      : irq_pending_capture
//  Description : Latches rising edges of request lines into a sticky pending
//                vector, cleared per bit by an indexed ack. Edges landing on a
//                bit that is still pending set a sticky overflow flag. The
//                pending output is masked by a per-bit enable.
//                Build option IRQ_SYNC_EN inserts a 2-flop synchronizer on
//                every request line (capture latency 3 instead of 1).
//  Revision    : 1.0  initial release
// ============================================================================
module irq_pending_capture
    import irq_pkg::*;
#(
    parameter int WIDTH = c_DEFAULT_WIDTH
) (
    input  wire logic            clk,
    input  wire logic            rst,
    irq_pending_capture_if.slave bus
);
    localparam int IDXW = idx_w(WIDTH);

    logic [WIDTH-1:0] w_req_s;
    logic [WIDTH-1:0] w_edge;
    logic [WIDTH-1:0] w_clr;
    logic [WIDTH-1:0] w_pending;
    logic [WIDTH-1:0] r_req_prev;
    logic [WIDTH-1:0] r_pend;
    logic [WIDTH-1:0] r_ovf;

`ifdef IRQ_SYNC_EN
    // Asynchronous sources: resynchronize every line before edge detection.
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_sync
        irq_sync2 u_sync (
            .clk (clk),
            .rst (rst),
            .d   (bus.req_in[gi]),
            .q   (w_req_s[gi])
        );
    end
`else
    // Sources are already synchronous to clk.
    assign w_req_s = bus.req_in;
`endif

    assign w_edge = w_req_s & ~r_req_prev;

    // Decode the ack strobe into a one-hot clear; out-of-range indices match nothing.
    always_comb begin
        w_clr = '0;
        for (int i = 0; i < WIDTH; i++) begin
            w_clr[i] = bus.ack && (bus.ack_idx == IDXW'(i));
        end
    end

    // Edge history, pending and overflow state; a new edge beats a same-cycle
    // ack, and an overflow clear beats a same-cycle lost event.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_req_prev <= '0;
            r_pend     <= '0;
            r_ovf      <= '0;
        end else begin
            r_req_prev <= w_req_s;
            r_pend     <= (r_pend & ~w_clr) | w_edge;
            r_ovf      <= bus.ovf_clr ? '0 : (r_ovf | (w_edge & r_pend & ~w_clr));
        end
    end

    // Outputs depend only on state and enable, never on ack or req_in.
    assign w_pending       = r_pend & bus.en;
    assign bus.pending     = w_pending;
    assign bus.any_pending = |w_pending;
    assign bus.overflow    = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_irq_pending_capture.sv
`default_nettype none
// ============================================================================
//  Module      : tb_irq_pending_capture
//  Description : Randomized and directed bench for irq_pending_capture with a
//                rule-level reference model and a queue-based scoreboard.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_irq_pending_capture;
    import irq_pkg::*;

    localparam int W = c_DEFAULT_WIDTH;
`ifdef IRQ_SYNC_EN
    localparam int DLY = 2;
`else
    localparam int DLY = 0;
`endif

    typedef struct {
        logic [W-1:0] pend;
        logic         any;
        logic [W-1:0] ovf;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    exp_t exp_q[$];

    // Reference model state: per-bit flags and the delayed request stream.
    logic         m_pend [W];
    logic         m_ovf  [W];
    logic         m_prev [W];
    logic [W-1:0] m_dly[$];

    irq_pending_capture_if #(.WIDTH(W)) bus ();

    irq_pending_capture #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [W-1:0] pack(input logic v [W]);
        logic [W-1:0] r;
        for (int i = 0; i < W; i++) r[i] = v[i];
        return r;
    endfunction

    task automatic compare(input string name, input logic [W-1:0] got_p, input logic got_a,
                           input logic [W-1:0] got_o, input exp_t e);
        checks++;
        if (got_p !== e.pend || got_a !== e.any || got_o !== e.ovf) begin
            errors++;
            $display("FAIL %s: got pending=%b any=%b overflow=%b, expected pending=%b any=%b overflow=%b",
                     name, got_p, got_a, got_o, e.pend, e.any, e.ovf);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < W; i++) begin
            m_pend[i] = 1'b0;
            m_ovf[i]  = 1'b0;
            m_prev[i] = 1'b0;
        end
        m_dly.delete();
        for (int k = 0; k < DLY; k++) m_dly.push_back('0);
    endtask

    // One clock edge worth of behaviour, applied bit by bit from the rules.
    task automatic model_step(input logic [W-1:0] req, input logic a, input ack_idx_t idx,
                              input logic oc);
        logic [W-1:0] req_s;
        m_dly.push_back(req);
        req_s = m_dly.pop_front();
        for (int i = 0; i < W; i++) begin
            bit rise  = req_s[i] && !m_prev[i];
            bit acked = a && (int'(idx) == i);
            bit lost  = rise && m_pend[i] && !acked;
            if (oc)        m_ovf[i] = 1'b0;
            else if (lost) m_ovf[i] = 1'b1;
            if (rise)       m_pend[i] = 1'b1;
            else if (acked) m_pend[i] = 1'b0;
            m_prev[i] = req_s[i];
        end
    endtask

    function automatic exp_t visible(input logic [W-1:0] en);
        exp_t e;
        e.pend = pack(m_pend) & en;
        e.any  = (e.pend != '0);
        e.ovf  = pack(m_ovf);
        return e;
    endfunction

    // Drive one cycle at the falling edge, check the combinational view of the
    // current state under the new enable, then queue the post-edge outcome.
    task automatic cyc(input logic r, input logic [W-1:0] req, input logic [W-1:0] en,
                       input logic a, input ack_idx_t idx, input logic oc);
        @(negedge clk);
        rst         = r;
        bus.req_in  = req;
        bus.en      = en;
        bus.ack     = a;
        bus.ack_idx = idx;
        bus.ovf_clr = oc;
        #1;
        if (r) model_reset();
        compare("comb_view", bus.pending, bus.any_pending, bus.overflow, visible(en));
        if (!r) model_step(req, a, idx, oc);
        exp_q.push_back(visible(en));
    endtask

    // Monitor: after every rising edge, compare against the oldest queued expectation.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                compare("post_edge", bus.pending, bus.any_pending, bus.overflow, exp_q.pop_front());
            end
        end
    end

    initial begin
        bus.req_in  = 4'b1010;
        bus.en      = 4'b1111;
        bus.ack     = 1'b0;
        bus.ack_idx = '0;
        bus.ovf_clr = 1'b0;
        model_reset();

        // Reset with lines already high, then release: captured on first edge.
        cyc(1, 4'b1010, 4'b1111, 0, 0, 0);
        cyc(1, 4'b1010, 4'b1111, 0, 0, 0);
        repeat (3) cyc(0, 4'b1010, 4'b1111, 0, 0, 0);
        cyc(0, 4'b0000, 4'b1111, 1, 3, 0);
        cyc(0, 4'b0000, 4'b1111, 1, 1, 0);
        repeat (2) cyc(0, 4'b0000, 4'b1111, 0, 0, 0);

        // Held request yields one event; ack clears it for good while held.
        repeat (5) cyc(0, 4'b0100, 4'b1111, 0, 0, 0);
        cyc(0, 4'b0100, 4'b1111, 1, 2, 0);
        repeat (4) cyc(0, 4'b0100, 4'b1111, 0, 0, 0);
        repeat (2) cyc(0, 4'b0000, 4'b1111, 0, 0, 0);

        // Second edge on an un-acked bit: overflow, then clear it.
        cyc(0, 4'b0001, 4'b1111, 0, 0, 0);
        repeat (3) cyc(0, 4'b0000, 4'b1111, 0, 0, 0);
        cyc(0, 4'b0001, 4'b1111, 0, 0, 0);
        repeat (3) cyc(0, 4'b0000, 4'b1111, 0, 0, 0);
        cyc(0, 4'b0000, 4'b1111, 0, 0, 1);
        cyc(0, 4'b0000, 4'b1111, 1, 0, 0);

        // Ack and new edge on the same bit: set wins, no overflow.
        cyc(0, 4'b0010, 4'b1111, 0, 0, 0);
        repeat (3) cyc(0, 4'b0000, 4'b1111, 0, 0, 0);
        cyc(0, 4'b0010, 4'b1111, 1, 1, 0);
        repeat (DLY) cyc(0, 4'b0010, 4'b1111, 1, 1, 0);
        repeat (3) cyc(0, 4'b0000, 4'b1111, 0, 0, 0);
        cyc(0, 4'b0000, 4'b1111, 1, 1, 0);

        // Disabled bits still capture; enabling exposes them immediately.
        repeat (4) cyc(0, 4'b1111, 4'b0000, 0, 0, 0);
        cyc(0, 4'b0000, 4'b1000, 0, 0, 0);
        cyc(0, 4'b0000, 4'b1111, 0, 0, 0);

        // Ack all four in descending order.
        cyc(0, 4'b0000, 4'b1111, 1, 3, 0);
        cyc(0, 4'b0000, 4'b1111, 1, 2, 0);
        cyc(0, 4'b0000, 4'b1111, 1, 1, 0);
        cyc(0, 4'b0000, 4'b1111, 1, 0, 0);
        repeat (2) cyc(0, 4'b1111, 4'b1111, 0, 0, 0);
        repeat (DLY + 1) cyc(0, 4'b1111, 4'b1111, 0, 0, 0);
        cyc(0, 4'b1111, 4'b1111, 1, 3, 0);
        cyc(0, 4'b1111, 4'b1111, 1, 2, 0);
        cyc(0, 4'b1111, 4'b1111, 1, 1, 0);
        cyc(0, 4'b1111, 4'b1111, 1, 0, 0);
        cyc(0, 4'b0000, 4'b1111, 0, 0, 1);

        // Randomized traffic, with an occasional mid-run async reset.
        for (int n = 0; n < 400; n++) begin
            logic [W-1:0] req = W'($urandom);
            logic [W-1:0] en  = ($urandom_range(0, 3) == 0) ? W'($urandom) : 4'b1111;
            logic         a   = ($urandom_range(0, 2) == 0);
            ack_idx_t     idx = ack_idx_t'($urandom_range(0, W - 1));
            logic         oc  = ($urandom_range(0, 15) == 0);
            logic         r   = ($urandom_range(0, 199) == 0);
            cyc(r, req, en, a, idx, oc);
        end

        repeat (3) @(posedge clk);
        #2;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d unchecked entries, expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/irq_pending_capture.md
Name: irq_pending_capture

Overview:
- Upstream stage of the n-bit priority encoder: turns raw request lines into a sticky, maskable pending vector that drives the encoder's `in` port.
- Rising edges on request lines are latched as pending events. Each bit stays set until the consumer acknowledges it by index, normally the encoder's `out` value.
- Lost events are tracked as per-bit sticky overflow flags.

Parameters:
- WIDTH, 4, number of request lines; must be ≥ 2. Matches the encoder's WIDTH.
- IDXW, $clog2(WIDTH), width of the ack index; derived, not overridden.

Ports:
- clk  input  1  system clock, rising-edge active
- rst  input  1  asynchronous, active-high reset
- req_in  input  WIDTH  raw request lines (level; events are rising edges)
- en  input  WIDTH  per-bit enable; 1 = bit visible on pending
- ack  input  1  acknowledge strobe, one-cycle pulse
- ack_idx  input  IDXW  index of the bit to clear when ack=1
- ovf_clr  input  1  clears the overflow vector
- pending  output  WIDTH  pend_q & en; connects to the encoder `in`
- any_pending  output  1  |pending
- overflow  output  WIDTH  sticky per-bit lost-event flags

Behaviour:
- Reset (async assert; synchronous deassert handled externally):
  - pend_q, req_prev, ovf_q are all 0.
  - Therefore pending, any_pending and overflow are all 0.
- Edge detect:
  - edge = req_s & ~req_prev, where req_s = req_in (see Optional Feature).
  - req_prev <= req_s every cycle.
  - A line already high when reset releases is captured as an event on the first clock edge.
- Ack decode:
  - clr[i] = ack & (ack_idx == i).
  - ack_idx ≥ WIDTH (non-power-of-2 WIDTH) is ignored.
  - Ack of a bit that is not pending has no effect and no error.
- Pending update, every clock: pend_q <= (pend_q & ~clr) | edge.
  - If set and clear hit the same bit in the same cycle, set wins; the new event is kept.
- Overflow update, every clock:
  - ovf_q <= ovf_clr ? 0 : ovf_q | (edge & pend_q & ~clr).
  - An edge onto an already-pending bit that is not being acked that cycle is a lost event.
  - ovf_clr and a new overflow in the same cycle: clear wins.
- Masking:
  - en gates only the pending output. Disabled bits still latch events and overflow.
  - Re-enabling a bit exposes its stored event immediately, combinationally.
- Latency:
  - Rising edge sampled at clock N: pending is high after edge N, i.e. one cycle.
  - Ack at clock N: bit is low after edge N.
  - pending and any_pending are combinational from registers and en only; there is no path from ack or req_in to the outputs.
- Held requests: a continuously high req_in generates exactly one event; a new event needs a low-then-high transition.
- Fully synchronous except reset. No state machine beyond the per-bit pending/overflow flops and the edge register.

Optional Feature:
- Macro: IRQ_SYNC_EN.
- Defined:
  - req_in passes through a 2-flop synchronizer per bit (reset to 0) before edge detection; req_s is the second flop.
  - Capture latency becomes 3 cycles.
  - Use this for asynchronous request sources.
- Undefined:
  - req_s = req_in directly; latency is 1 cycle.
  - req_in must be synchronous to clk.

Decomposition:
- Shared package irq_pkg:
  - Default WIDTH constant.
  - Function idx_w(width) returning the index width, replacing inline $clog2 so encoder and capture agree.
  - typedef for the ack-index type.
- One natural sub-module: irq_sync2, the per-bit 2-flop synchronizer, instantiated only under IRQ_SYNC_EN.
- Edge, pending and overflow logic stay inline.

Test Plan (WIDTH=4, IRQ_SYNC_EN undefined, en=4'b1111 unless stated):
- rst=1 with req_in=4'b1010 → pending=0, overflow=0, any_pending=0. Release rst, one clock → pending=4'b1010.
- req_in 0→4'b0100, held 5 cycles → pending=4'b0100 after 1 clock. Ack with ack_idx=2 → pending=0 next cycle and stays 0 while req_in is held high.
- bit0 pending; req_in[0] low then high again with no ack → pending[0]=1 and overflow=4'b0001. ovf_clr=1 → overflow=0.
- bit1 pending; in the same cycle ack with ack_idx=1 and a new rising edge on req_in[1] → pending[1] stays 1, overflow[1] stays 0.
- en=4'b0000 with edges on all bits → pending=0, any_pending=0. Set en=4'b1000 → pending=4'b1000 in the same cycle. Encoder driven by pending gives out=3, valid=1.
- Rising edges on all bits, then ack ack_idx=3,2,1,0 on consecutive cycles → pending steps 1111→0111→0011→0001→0000. Repeat with IRQ_SYNC_EN defined and confirm capture latency is 3 cycles.
